// File: rtl/riscv_pkg.sv
// riscv_pkg: opcode/funct3 constants and PC sequencer states shared by the fetch logic.
package riscv_pkg;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    typedef enum logic [1:0] {BOOT, RUN, HALT} pc_state_t;
endpackage

// File: rtl/riscv_branch_cmp.sv
// riscv_branch_cmp: combinational branch condition evaluation from funct3 and operands.
module riscv_branch_cmp
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        taken
);
    logic eq, lt, ltu;
    always_comb begin
        eq  = rs1 == rs2;
        lt  = $signed(rs1) < $signed(rs2);
        ltu = rs1 < rs2;
        taken = funct3 == F3_BEQ  ? eq   :
                funct3 == F3_BNE  ? !eq  :
                funct3 == F3_BLT  ? lt   :
                funct3 == F3_BGE  ? !lt  :
                funct3 == F3_BLTU ? ltu  :
                funct3 == F3_BGEU ? !ltu : 1'b0;
    end
endmodule

// File: rtl/riscv_pc_controller.sv
// riscv_pc_controller: owns the PC, tags EX with PC/valid, resolves control transfers
// with a one-bubble squash and halts on a misaligned taken target.
module riscv_pc_controller
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic [6:0]  ex_opcode_i,
    input  logic [2:0]  ex_funct3_i,
    input  logic [31:0] ex_imm_i_i,
    input  logic [31:0] ex_imm_b_i,
    input  logic [31:0] ex_imm_j_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    output logic [31:0] pc_f_o,
    output logic [31:0] ex_pc_o,
    output logic        ex_valid_o,
    output logic [31:0] link_o,
    output logic        redirect_o,
    output logic        halted_o
);
    pc_state_t   state;
    logic        br_taken, xfer, misaligned;
    logic [31:0] target;

    riscv_branch_cmp u_cmp (
        .funct3 (ex_funct3_i),
        .rs1    (rs1_data_i),
        .rs2    (rs2_data_i),
        .taken  (br_taken)
    );

    // Bubbles and the HALT/BOOT slots carry ex_valid_o=0, so they can never transfer.
    always_comb begin
        target = ex_opcode_i == OP_JAL  ? ex_pc_o + ex_imm_j_i :
                 ex_opcode_i == OP_JALR ? (rs1_data_i + ex_imm_i_i) & ~32'h1 :
                                          ex_pc_o + ex_imm_b_i;
        xfer = ex_valid_o && ((ex_opcode_i == OP_BRANCH && br_taken) ||
                              ex_opcode_i == OP_JAL || ex_opcode_i == OP_JALR);
        misaligned = target[1:0] != 2'b00;
        redirect_o = xfer && !misaligned && !stall_i;
        link_o = ex_pc_o + 32'd4;
        halted_o = state == HALT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BOOT;
            pc_f_o     <= RESET_PC;
            ex_pc_o    <= '0;
            ex_valid_o <= 1'b0;
        end else if (!stall_i) begin
            unique case (state)
                BOOT: begin
                    state      <= RUN;
                    ex_pc_o    <= pc_f_o;
                    ex_valid_o <= 1'b1;
                    pc_f_o     <= pc_f_o + 32'd4;
                end
                RUN: begin
                    if (xfer && misaligned) begin
                        state      <= HALT;
                        ex_valid_o <= 1'b0;
                    end else begin
                        ex_pc_o    <= pc_f_o;
                        ex_valid_o <= !xfer;
                        pc_f_o     <= xfer ? target : pc_f_o + 32'd4;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_pc_controller.sv
// tb_riscv_pc_controller: vector table, directed corner sequences and a randomized
// comparison against a rule-level model of the fetch sequencer.
module tb_riscv_pc_controller;
    localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, NOP = 7'b0010011;

    logic        clk = 0, rst = 1, stall_i = 0;
    logic [6:0]  ex_opcode_i = NOP;
    logic [2:0]  ex_funct3_i = 0;
    logic [31:0] ex_imm_i_i = 0, ex_imm_b_i = 0, ex_imm_j_i = 0, rs1_data_i = 0, rs2_data_i = 0;
    logic [31:0] pc_f_o, ex_pc_o, link_o;
    logic        ex_valid_o, redirect_o, halted_o;
    int tests = 0, fails = 0;

    riscv_pc_controller #(.RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i),
        .ex_opcode_i(ex_opcode_i), .ex_funct3_i(ex_funct3_i),
        .ex_imm_i_i(ex_imm_i_i), .ex_imm_b_i(ex_imm_b_i), .ex_imm_j_i(ex_imm_j_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .pc_f_o(pc_f_o), .ex_pc_o(ex_pc_o), .ex_valid_o(ex_valid_o),
        .link_o(link_o), .redirect_o(redirect_o), .halted_o(halted_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] a, b, imm;
        logic        exp;
    } vec_t;
    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm);
        ex_opcode_i = op; ex_funct3_i = f3; rs1_data_i = a; rs2_data_i = b;
        ex_imm_i_i = imm; ex_imm_b_i = imm; ex_imm_j_i = imm;
    endtask

    task automatic expect_state(input string tag, input logic [31:0] pc, input logic [31:0] epc,
                                input logic ev, input logic h);
        check({tag, " pc_f"}, pc_f_o, pc);
        check({tag, " ex_pc"}, ex_pc_o, epc);
        check({tag, " ex_valid"}, {31'b0, ex_valid_o}, {31'b0, ev});
        check({tag, " halted"}, {31'b0, halted_o}, {31'b0, h});
    endtask

    // Reference model: architectural rules written directly on PC values.
    logic [31:0] m_pc, m_epc;
    logic        m_ev, m_halt, m_boot;

    function automatic logic cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic m_taken();
        if (!m_ev) return 1'b0;
        if (ex_opcode_i == JAL || ex_opcode_i == JALR) return 1'b1;
        return ex_opcode_i == BR && cond(ex_funct3_i, rs1_data_i, rs2_data_i);
    endfunction

    function automatic logic [31:0] m_target();
        if (ex_opcode_i == JAL) return m_epc + ex_imm_j_i;
        if (ex_opcode_i == JALR) return (rs1_data_i + ex_imm_i_i) & 32'hFFFF_FFFE;
        return m_epc + ex_imm_b_i;
    endfunction

    task automatic model_edge();
        logic tk;
        logic [31:0] t;
        tk = m_taken();
        t = m_target();
        if (rst) begin
            m_pc = 0; m_epc = 0; m_ev = 0; m_halt = 0; m_boot = 1;
        end else if (m_halt || stall_i) begin
        end else if (m_boot) begin
            m_epc = m_pc; m_ev = 1; m_pc = m_pc + 4; m_boot = 0;
        end else if (tk && (t % 4) != 0) begin
            m_halt = 1; m_ev = 0;
        end else begin
            m_epc = m_pc; m_ev = !tk; m_pc = tk ? t : m_pc + 4;
        end
    endtask

    initial begin
        vecs[0]  = '{BR, 3'd0, 32'd5, 32'd5, 32'd8, 1'b1};
        vecs[1]  = '{BR, 3'd0, 32'd5, 32'd6, 32'd8, 1'b0};
        vecs[2]  = '{BR, 3'd1, 32'd5, 32'd6, 32'd8, 1'b1};
        vecs[3]  = '{BR, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'd8, 1'b1};
        vecs[4]  = '{BR, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'd8, 1'b0};
        vecs[5]  = '{BR, 3'd5, 32'd1, 32'hFFFF_FFFF, 32'd8, 1'b1};
        vecs[6]  = '{BR, 3'd7, 32'd1, 32'hFFFF_FFFF, 32'd8, 1'b0};
        vecs[7]  = '{BR, 3'd5, 32'd7, 32'd7, 32'd8, 1'b1};
        vecs[8]  = '{BR, 3'd6, 32'd1, 32'hFFFF_FFFF, 32'd8, 1'b1};
        vecs[9]  = '{BR, 3'd2, 32'd3, 32'd3, 32'd8, 1'b0};
        vecs[10] = '{BR, 3'd3, 32'd3, 32'd4, 32'd8, 1'b0};
        vecs[11] = '{JAL, 3'd0, 32'd0, 32'd0, 32'h100, 1'b1};
        vecs[12] = '{JALR, 3'd0, 32'h101, 32'd0, 32'd3, 1'b1};
        vecs[13] = '{JALR, 3'd0, 32'h101, 32'd0, 32'd2, 1'b0};
        vecs[14] = '{BR, 3'd0, 32'd9, 32'd9, 32'd6, 1'b0};
        vecs[15] = '{BR, 3'd1, 32'd9, 32'd9, 32'd6, 1'b0};
        vecs[16] = '{7'b0110011, 3'd0, 32'd1, 32'd1, 32'd8, 1'b0};

        // Reset, then sequential NOP fetch
        rst = 1; drive(NOP, 0, 0, 0, 0);
        step();
        expect_state("reset", 32'h0, 32'h0, 1'b0, 1'b0);
        check("reset redirect", {31'b0, redirect_o}, 32'd0);
        rst = 0;
        for (int i = 1; i <= 4; i++) begin
            step();
            expect_state($sformatf("nop%0d", i), 32'(4 * i), 32'(4 * (i - 1)), 1'b1, 1'b0);
        end
        // BEQ at 0x10, +8, equal operands
        step();
        drive(BR, 3'd0, 32'd5, 32'd5, 32'd8);
        #1 check("beq redirect", {31'b0, redirect_o}, 32'd1);
        step();
        expect_state("beq bubble", 32'h18, 32'h14, 1'b0, 1'b0);
        drive(NOP, 0, 0, 0, 0);
        step();
        expect_state("beq target", 32'h1C, 32'h18, 1'b1, 1'b0);
        // JAL at 0x20 back to 0 with a 3-cycle stall
        step();
        step();
        expect_state("pre jal", 32'h24, 32'h20, 1'b1, 1'b0);
        drive(JAL, 0, 0, 0, -32'sd32);
        stall_i = 1;
        #1 check("jal stalled redirect", {31'b0, redirect_o}, 32'd0);
        check("jal link", link_o, 32'h24);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_state("jal stall", 32'h24, 32'h20, 1'b1, 1'b0);
        end
        stall_i = 0;
        #1 check("jal redirect", {31'b0, redirect_o}, 32'd1);
        step();
        expect_state("jal bubble", 32'h0, 32'h24, 1'b0, 1'b0);
        drive(BR, 3'd0, 32'd1, 32'd1, 32'd8);
        #1 check("squashed slot redirect", {31'b0, redirect_o}, 32'd0);
        step();
        expect_state("after squash", 32'h4, 32'h0, 1'b1, 1'b0);
        // JALR misaligned at 0x40 -> HALT, then reset recovers
        rst = 1; drive(NOP, 0, 0, 0, 0);
        step();
        rst = 0;
        for (int i = 0; i < 17; i++) step();
        expect_state("pre jalr", 32'h44, 32'h40, 1'b1, 1'b0);
        drive(JALR, 0, 32'h101, 0, 32'd2);
        #1 check("jalr misaligned redirect", {31'b0, redirect_o}, 32'd0);
        step();
        expect_state("halt", 32'h44, 32'h40, 1'b0, 1'b1);
        drive(JAL, 0, 0, 0, 32'd8);
        step(); step();
        expect_state("halt frozen", 32'h44, 32'h40, 1'b0, 1'b1);
        check("halt redirect", {31'b0, redirect_o}, 32'd0);
        rst = 1;
        step();
        expect_state("halt reset", 32'h0, 32'h0, 1'b0, 1'b0);
        rst = 0; drive(NOP, 0, 0, 0, 0);
        step();
        expect_state("reboot", 32'h4, 32'h0, 1'b1, 1'b0);
        // Table: combinational redirect decisions with ex_pc=0, ex_valid=1
        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].imm);
            #1 check($sformatf("vec%0d redirect", i), {31'b0, redirect_o}, {31'b0, vecs[i].exp});
        end
        // Randomized run against the model
        rst = 1; stall_i = 0; drive(NOP, 0, 0, 0, 0);
        model_edge();
        step();
        for (int c = 0; c < 3000; c++) begin
            int sel;
            logic [31:0] imm, a;
            rst = $urandom_range(0, 99) < 4;
            stall_i = $urandom_range(0, 4) == 0;
            sel = $urandom_range(0, 9);
            imm = 32'($urandom_range(0, 63) * 4) - 32'd128;
            if ($urandom_range(0, 15) == 0) imm = imm + 2;
            a = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
            drive(sel < 4 ? BR : sel == 4 ? JAL : sel == 5 ? JALR : sel < 8 ? NOP : 7'($urandom),
                  3'($urandom), a, $urandom_range(0, 1) ? a : $urandom, imm);
            #1;
            check("rnd redirect", {31'b0, redirect_o},
                  {31'b0, m_taken() && !stall_i && (m_target() % 4) == 0});
            check("rnd link", link_o, m_epc + 4);
            expect_state("rnd", m_pc, m_epc, m_ev, m_halt);
            model_edge();
            step();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
